// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one
// single-outstanding memory port, data first with a bounded burst.
module mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MAX_DBURST = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_be,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [DW/8-1:0] m_be,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   input  logic            m_ack,
   input  logic [DW-1:0]   m_rdata,
   output logic            busy
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned CW =
      (MAX_DBURST > 0) ? $clog2(MAX_DBURST + 1) : 1;
   localparam logic [CW-1:0] DMAX = CW'(MAX_DBURST);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   dcnt_q, dcnt_d;
   logic            i_win, d_win;

   logic            m_req_q;
   logic            m_we_q;
   logic [BW-1:0]   m_be_q;
   logic [AW-1:0]   m_addr_q;
   logic [DW-1:0]   m_wdata_q;
   logic            i_rvalid_q, d_rvalid_q;
   logic [DW-1:0]   i_rdata_q, d_rdata_q;

   // Winner selection, burst counter and next state
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      i_win   = 1'b0;
      d_win   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A starved fetch overrides data once the burst limit is hit
            if (i_req && (!d_req || dcnt_q == DMAX)) begin
               i_win = 1'b1;
            end else if (d_req) begin
               d_win = 1'b1;
            end
            if (i_win) begin
               state_d = BUSY_I;
               dcnt_d  = '0;
            end else if (d_win) begin
               state_d = BUSY_D;
               dcnt_d  = i_req ? dcnt_q + CW'(1) : '0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (m_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grants are held low while reset is asserted
   assign i_gnt = i_win & reset_n;
   assign d_gnt = d_win & reset_n;

   // State register and burst counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Memory request capture and response return
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_be_q     <= '0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         if (i_gnt) begin
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_be_q    <= '1;
            m_addr_q  <= i_addr;
            m_wdata_q <= '0;
         end else if (d_gnt) begin
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_be_q    <= d_be;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
         end else if (m_ack && state_q == BUSY_I) begin
            m_req_q    <= 1'b0;
            i_rvalid_q <= 1'b1;
            i_rdata_q  <= m_rdata;
         end else if (m_ack && state_q == BUSY_D) begin
            m_req_q    <= 1'b0;
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= m_we_q ? '0 : m_rdata;
         end
      end
   end

   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_be     = m_be_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign i_rvalid = i_rvalid_q;
   assign i_rdata  = i_rdata_q;
   assign d_rvalid = d_rvalid_q;
   assign d_rdata  = d_rdata_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: port drivers, a memory responder
// and a negedge monitor popping expected responses.
module tb_mem_arbiter;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   localparam byte GD = 8'h44;
   localparam byte GI = 8'h49;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req, m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        busy;

   mem_arbiter #(.AW(32), .DW(32), .MAX_DBURST(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_be(m_be),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   req_t        d_stim[$], i_stim[$];
   logic [31:0] d_exp[$], i_exp[$];
   byte         gnt_exp[$];
   req_t        d_cur, i_cur, m_exp;
   bit          d_acc = 0, i_acc = 0;
   bit          chk_m = 0, m_exp_d = 0;
   bit          mem_en = 1;
   int          ack_delay = 2;
   int          ack_own = 0;
   int          cyc = 0, last_ig = -1;
   bit          zw_on = 0;
   int          zw_n = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Port drivers and memory responder, just after each rising edge
   initial begin
      int wcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (d_acc) begin
            d_acc = 0;
            d_req = 1'b0;
         end
         if (!d_req && d_stim.size() > 0) begin
            d_cur   = d_stim.pop_front();
            d_req   = 1'b1;
            d_we    = d_cur.we;
            d_be    = d_cur.be;
            d_addr  = d_cur.addr;
            d_wdata = d_cur.wdata;
            d_exp.push_back(d_cur.we ? 32'h0 : memfn(d_cur.addr));
         end
         if (i_acc) begin
            i_acc = 0;
            i_req = 1'b0;
         end
         if (!i_req && i_stim.size() > 0) begin
            i_cur  = i_stim.pop_front();
            i_req  = 1'b1;
            i_addr = i_cur.addr;
            i_exp.push_back(memfn(i_cur.addr));
         end
         if (mem_en) begin
            if (m_req) begin
               if (wcnt == ack_delay) begin
                  m_ack   = 1'b1;
                  m_rdata = memfn(m_addr);
               end else begin
                  m_ack = 1'b0;
               end
               wcnt++;
            end else begin
               m_ack = 1'b0;
               wcnt  = 0;
            end
         end
      end
   end

   // Monitor on the falling edge
   initial forever begin
      @(negedge clk);
      cyc++;
      if (ack_own == 1) check("i_rv_lat", i_rvalid, 1'b1);
      if (ack_own == 2) check("d_rv_lat", d_rvalid, 1'b1);
      ack_own = 0;
      if (m_req && m_ack) ack_own = m_exp_d ? 2 : 1;
      if (chk_m) begin
         chk_m = 0;
         check("m_req", m_req, 1'b1);
         check("busy", busy, 1'b1);
         check("m_addr", m_addr, m_exp.addr);
         check("m_we", m_we, m_exp.we);
         if (m_exp_d) begin
            check("m_be", m_be, m_exp.be);
            check("m_wdata", m_wdata, m_exp.wdata);
         end
      end
      if (i_gnt || d_gnt) begin
         check("one_gnt", i_gnt & d_gnt, 1'b0);
         if (gnt_exp.size() > 0)
            check("gnt_order", d_gnt ? GD : GI, gnt_exp.pop_front());
      end
      if (d_gnt) begin
         m_exp   = d_cur;
         m_exp_d = 1;
         chk_m   = 1;
         d_acc   = 1;
      end else if (i_gnt) begin
         m_exp   = '{we: 1'b0, be: 4'hF, addr: i_cur.addr, wdata: 32'h0};
         m_exp_d = 0;
         chk_m   = 1;
         i_acc   = 1;
         if (zw_on) begin
            if (last_ig >= 0) check("i_gnt_gap", cyc - last_ig, 2);
            last_ig = cyc;
            zw_n++;
         end
      end
      if (i_rvalid) begin
         check("i_rv_q", i_exp.size() > 0, 1'b1);
         if (i_exp.size() > 0) check("i_rdata", i_rdata, i_exp.pop_front());
      end
      if (d_rvalid) begin
         check("d_rv_q", d_exp.size() > 0, 1'b1);
         if (d_exp.size() > 0) check("d_rdata", d_rdata, d_exp.pop_front());
      end
   end

   task automatic wait_idle(input int budget);
      int k = 0;
      while (k < budget &&
             !(d_stim.size() == 0 && i_stim.size() == 0 &&
               d_exp.size() == 0 && i_exp.size() == 0 &&
               !d_req && !i_req && !busy)) begin
         @(negedge clk);
         k++;
      end
      check("idle_wait", k < budget, 1'b1);
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, {i_gnt, d_gnt}, 2'b00);
      check({tag, "_rv"}, {i_rvalid, d_rvalid}, 2'b00);
      check({tag, "_rdata"}, {i_rdata, d_rdata}, 64'h0);
      check({tag, "_mreq"}, {m_req, m_we, m_be}, 6'h0);
      check({tag, "_maddr"}, m_addr, 32'h0);
      check({tag, "_mwdata"}, m_wdata, 32'h0);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      int k;
      // Read at 0x100 is presented while still in reset
      d_stim.push_back('{we: 1'b0, be: 4'hF, addr: 32'h100, wdata: 32'h0});
      repeat (3) @(posedge clk);
      #1;
      check_zero("rst");
      @(posedge clk);
      #2 reset_n = 1'b1;
      #1 check("first_gnt", d_gnt, 1'b1);
      wait_idle(50);

      // Partial write
      d_stim.push_back('{we: 1'b1, be: 4'h3, addr: 32'h200,
                         wdata: 32'h12345678});
      wait_idle(50);

      // Simultaneous requests: data first
      ack_delay = 1;
      gnt_exp.push_back(GD);
      gnt_exp.push_back(GI);
      d_stim.push_back('{we: 1'b0, be: 4'hF, addr: 32'h300, wdata: 32'h0});
      i_stim.push_back('{we: 1'b0, be: 4'hF, addr: 32'h1000, wdata: 32'h0});
      wait_idle(50);
      check("gnt40_left", gnt_exp.size(), 0);

      // Burst limit: D,D,I,D,D,I
      ack_delay = 0;
      gnt_exp.push_back(GD);
      gnt_exp.push_back(GD);
      gnt_exp.push_back(GI);
      gnt_exp.push_back(GD);
      gnt_exp.push_back(GD);
      gnt_exp.push_back(GI);
      for (int n = 0; n < 4; n++)
         d_stim.push_back('{we: 1'b0, be: 4'hF,
                            addr: 32'h400 + 32'(n * 4), wdata: 32'h0});
      i_stim.push_back('{we: 1'b0, be: 4'hF, addr: 32'h2000, wdata: 32'h0});
      i_stim.push_back('{we: 1'b0, be: 4'hF, addr: 32'h2004, wdata: 32'h0});
      wait_idle(80);
      check("gnt41_left", gnt_exp.size(), 0);

      // Zero-wait back-to-back fetches
      zw_on = 1;
      last_ig = -1;
      zw_n = 0;
      for (int n = 0; n < 4; n++)
         i_stim.push_back('{we: 1'b0, be: 4'hF,
                            addr: 32'h3000 + 32'(n * 4), wdata: 32'h0});
      wait_idle(80);
      zw_on = 0;
      check("zw_grants", zw_n, 4);

      // Reset while a data read is outstanding
      mem_en = 0;
      d_stim.push_back('{we: 1'b0, be: 4'hF, addr: 32'h500, wdata: 32'h0});
      k = 0;
      while (!busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("busy_d", busy, 1'b1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_zero("mid");
      d_exp.delete();
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1 m_ack = 1'b1;
      m_rdata = 32'hBAD0BAD0;
      @(posedge clk);
      #1 m_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("late_busy", busy, 1'b0);
      check("late_mreq", m_req, 1'b0);
      check("late_drv", d_rvalid, 1'b0);

      // Normal traffic after the abandoned transaction
      mem_en = 1;
      ack_delay = 1;
      d_stim.push_back('{we: 1'b0, be: 4'hF, addr: 32'h600, wdata: 32'h0});
      wait_idle(50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
